// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO for a UART: queues {framing error, byte} entries and
// presents the oldest one first-word-fall-through with a sticky overflow flag.
module uart_rx_fifo #(
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6
) (
    input  logic                     clk_i,
    input  logic                     arst_n_i,
    input  logic [7:0]               rx_byte_i,
    input  logic                     rx_valid_i,
    input  logic                     rx_ferr_i,
    output logic [7:0]               m_data_o,
    output logic                     m_ferr_o,
    output logic                     m_valid_o,
    input  logic                     m_ready_i,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     almost_full_o,
    output logic                     overflow_o,
    input  logic                     clr_ovf_i
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [LW-1:0] AF_LVL   = LW'(AF_LEVEL);
    localparam logic [LW-1:0] ONE_LVL  = LW'(1);

    logic [8:0]    mem_q [DEPTH];
    logic [8:0]    head;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          ovf_q, ovf_d;
    logic          valid, full, push, pop, drop;

    always_comb begin
        valid = (level_q != '0);
        full  = (level_q == FULL_LVL);
        pop   = valid & m_ready_i;
        // A full FIFO still accepts a byte when the head leaves in the same cycle.
        push  = rx_valid_i & (~full | pop);
        drop  = rx_valid_i & full & ~pop;

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + ONE_LVL;
            2'b01:   level_d = level_q - ONE_LVL;
            default: level_d = level_q;
        endcase

        // A drop in the same cycle as a clear leaves the flag set.
        ovf_d = ovf_q;
        if (drop)
            ovf_d = 1'b1;
        else if (clr_ovf_i)
            ovf_d = 1'b0;
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is deliberately left unreset; the pointers alone define what is valid.
    always_ff @(posedge clk_i) begin
        if (push)
            mem_q[wr_ptr_q] <= {rx_ferr_i, rx_byte_i};
    end

    always_comb begin
        head          = mem_q[rd_ptr_q];
        m_valid_o     = valid;
        m_data_o      = valid ? head[7:0] : 8'h00;
        m_ferr_o      = valid ? head[8]   : 1'b0;
        level_o       = level_q;
        almost_full_o = (level_q >= AF_LVL);
        overflow_o    = ovf_q;
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: a queue model predicts every output
// each cycle, and popped heads are compared against the queued entries.
module tb_uart_rx_fifo;
    localparam int DEPTH    = 8;
    localparam int AF_LEVEL = 6;

    logic       clk = 1'b0;
    logic       arst_n;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_ferr;
    logic [7:0] m_data;
    logic       m_ferr;
    logic       m_valid;
    logic       m_ready;
    logic [3:0] level;
    logic       almost_full;
    logic       overflow;
    logic       clr_ovf;

    int n_tests = 0;
    int n_fail  = 0;

    logic [8:0] sb_q[$];
    logic       exp_ovf = 1'b0;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) dut (
        .clk_i        (clk),
        .arst_n_i     (arst_n),
        .rx_byte_i    (rx_byte),
        .rx_valid_i   (rx_valid),
        .rx_ferr_i    (rx_ferr),
        .m_data_o     (m_data),
        .m_ferr_o     (m_ferr),
        .m_valid_o    (m_valid),
        .m_ready_i    (m_ready),
        .level_o      (level),
        .almost_full_o(almost_full),
        .overflow_o   (overflow),
        .clr_ovf_i    (clr_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Compare every output against the model state.
    task automatic chk_state(input string tag);
        int sz;
        sz = sb_q.size();
        chk({tag, ".level"}, 32'(level), 32'(sz));
        chk({tag, ".valid"}, 32'(m_valid), 32'(sz > 0));
        chk({tag, ".af"}, 32'(almost_full), 32'(sz >= AF_LEVEL));
        chk({tag, ".ovf"}, 32'(overflow), 32'(exp_ovf));
        if (sz > 0) begin
            chk({tag, ".data"}, 32'(m_data), 32'(sb_q[0][7:0]));
            chk({tag, ".ferr"}, 32'(m_ferr), 32'(sb_q[0][8]));
        end else begin
            chk({tag, ".data0"}, 32'(m_data), 32'h0);
            chk({tag, ".ferr0"}, 32'(m_ferr), 32'h0);
        end
    endtask

    // Called at a negedge: drive inputs, predict, clock once, check at next negedge.
    task automatic cycle(input logic v, input logic [7:0] b, input logic fe,
                         input logic rdy, input logic clr, input string tag);
        logic mpop;
        rx_valid = v;
        rx_byte  = b;
        rx_ferr  = fe;
        m_ready  = rdy;
        clr_ovf  = clr;
        #1;
        mpop = (sb_q.size() > 0) && rdy;
        if (mpop) begin
            chk({tag, ".pop_data"}, 32'(m_data), 32'(sb_q[0][7:0]));
            chk({tag, ".pop_ferr"}, 32'(m_ferr), 32'(sb_q[0][8]));
            void'(sb_q.pop_front());
        end
        if (v) begin
            if (sb_q.size() < DEPTH)
                sb_q.push_back({fe, b});
            else
                exp_ovf = 1'b1;
        end else if (clr) begin
            exp_ovf = 1'b0;
        end
        if (v && sb_q.size() == DEPTH && !mpop && clr)
            exp_ovf = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rx_valid = 1'b0;
        m_ready  = 1'b0;
        clr_ovf  = 1'b0;
        chk_state(tag);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < DEPTH + 2; i++)
            cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, tag);
    endtask

    initial begin
        arst_n   = 1'b0;
        rx_byte  = 8'h00;
        rx_valid = 1'b0;
        rx_ferr  = 1'b0;
        m_ready  = 1'b0;
        clr_ovf  = 1'b0;
        #3;
        chk_state("reset");
        @(negedge clk);
        arst_n = 1'b1;

        // Single byte: visible one cycle later, then popped.
        cycle(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, "a5_push");
        chk("a5_data", 32'(m_data), 32'hA5);
        chk("a5_level", 32'(level), 32'd1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "a5_pop");
        chk("a5_empty", 32'(m_valid), 32'd0);

        // Fill to full, then overflow.
        for (int i = 1; i <= DEPTH; i++)
            cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, "fill");
        chk("full_level", 32'(level), 32'd8);
        cycle(1'b1, 8'h09, 1'b0, 1'b0, 1'b0, "ovf9");
        chk("ovf_set", 32'(overflow), 32'd1);

        // Clear collides with another drop: drop wins; then a lone clear works.
        cycle(1'b1, 8'h77, 1'b0, 1'b0, 1'b1, "clr_vs_drop");
        chk("ovf_kept", 32'(overflow), 32'd1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "clr_alone");
        chk("ovf_cleared", 32'(overflow), 32'd0);

        // Full with simultaneous push and pop.
        cycle(1'b1, 8'h55, 1'b0, 1'b1, 1'b0, "full_pushpop");
        chk("fp_level", 32'(level), 32'd8);
        chk("fp_ovf", 32'(overflow), 32'd0);
        drain("drain1");

        // Framing-error byte is queued with its flag.
        cycle(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, "ferr_push");
        chk("ferr_flag", 32'(m_ferr), 32'd1);
        chk("ferr_data", 32'(m_data), 32'h3C);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "ferr_pop");

        // Interleaved traffic to wrap the pointers several times.
        for (int i = 0; i < 20; i++)
            cycle(1'b1, 8'($urandom_range(255)), 1'($urandom_range(1)),
                  (i % 3) != 0, 1'b0, "wrap");
        for (int i = 0; i < 20; i++)
            cycle(1'($urandom_range(1)), 8'($urandom_range(255)), 1'($urandom_range(1)),
                  1'($urandom_range(1)), 1'b0, "mixed");
        drain("drain2");

        // Build level 5 with overflow set, then reset asynchronously mid-cycle.
        for (int i = 0; i < DEPTH + 1; i++)
            cycle(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0, "pre_rst");
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "pre_rst_pop");
        chk("pre_rst_level", 32'(level), 32'd5);
        #2;
        arst_n = 1'b0;
        #1;
        sb_q.delete();
        exp_ovf = 1'b0;
        chk_state("async_rst");
        @(negedge clk);
        arst_n = 1'b1;
        chk("post_rst_level", 32'(level), 32'd0);
        cycle(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, "first_push");
        chk("first_push_lvl", 32'(level), 32'd1);
        drain("drain3");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
